// File: rtl/axi_mem_snk_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_mem_snk_pkg
// Desc   : Burst types, response codes, FSM state encodings and address helpers
//          for axi_mem_snk. WRAP support is enabled by AXI_MEM_SNK_WRAP_EN.
// Rev    : 1.0
// ============================================================================
package axi_mem_snk_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE = 2'd0;
  localparam wr_state_t W_DATA = 2'd1;
  localparam wr_state_t W_RESP = 2'd2;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t R_IDLE = 1'b0;
  localparam rd_state_t R_DATA = 1'b1;

  // Whole-burst error: reserved type, or WRAP that is unsupported / has a bad length.
  function automatic logic burst_err(input logic [7:0] len, input logic [1:0] burst);
    logic e;
    e = 1'b0;
    case (burst)
      BURST_RSVD: e = 1'b1;
      BURST_WRAP: begin
`ifdef AXI_MEM_SNK_WRAP_EN
        e = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
`else
        e = 1'b1;
`endif
      end
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] step;
    logic [63:0] aligned;
    logic [63:0] res;
`ifdef AXI_MEM_SNK_WRAP_EN
    logic [63:0] bound;
    bound = ({56'd0, len} + 64'd1) << size;
`endif
    step    = 64'd1 << size;
    aligned = addr & ~(step - 64'd1);
    case (burst)
      BURST_INCR: res = aligned + step;
`ifdef AXI_MEM_SNK_WRAP_EN
      BURST_WRAP: res = (addr & ~(bound - 64'd1)) | ((aligned + step) & (bound - 64'd1));
`endif
      default:    res = addr;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_snk_burst_addr.sv
`default_nettype none
// ============================================================================
// Module : axi_mem_snk_burst_addr
// Desc   : Per-burst address generator: latches start fields, tracks beat index,
//          flags last beat and whole-burst error. WRAP via AXI_MEM_SNK_WRAP_EN.
// Rev    : 1.0
// ============================================================================
module axi_mem_snk_burst_addr
  import axi_mem_snk_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_SIZE   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic [7:0]            beat_o,
  output logic                  last_o,
  output logic                  err_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt;
  logic [7:0]            len_q, len_d, beat_q, beat_d;
  logic [2:0]            size_q, size_d, size_clamped;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;

  // Sizes wider than the bus behave as full-width transfers.
  assign size_clamped = (size_i > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size_i;
  assign addr_nxt     = ADDR_WIDTH'(next_addr(64'(addr_q), len_q, size_q, burst_q));

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    if (start_i) begin
      addr_d  = addr_i;
      len_d   = len_i;
      beat_d  = 8'd0;
      size_d  = size_clamped;
      burst_d = burst_i;
      err_d   = burst_err(len_i, burst_i);
    end else if (advance_i) begin
      addr_d = addr_nxt;
      beat_d = beat_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end

  assign addr_o      = addr_q;
  assign next_addr_o = addr_nxt;
  assign beat_o      = beat_q;
  assign last_o      = (beat_q == len_q);
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: rtl/axi_mem_snk.sv
`default_nettype none
// ============================================================================
// Module : axi_mem_snk
// Desc   : AXI4 slave backed by an internal byte-addressable RAM, independent
//          read/write channels. Define AXI_MEM_SNK_WRAP_EN to support WRAP.
// Rev    : 1.0
// ============================================================================
module axi_mem_snk
  import axi_mem_snk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [3:0]              awcache,
  input  logic                    awlock,
  input  logic [2:0]              awprot,
  input  logic [3:0]              awqos,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic [3:0]              arcache,
  input  logic                    arlock,
  input  logic [2:0]              arprot,
  input  logic [3:0]              arqos,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int WORDS = MEM_BYTES / BYTES;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  wr_state_t             wr_state_q, wr_state_d;
  logic                  wr_acc_q, wr_acc_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wr_start, wr_adv, wr_we, wr_beat_bad, wr_acc_now;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_next_addr;
  logic [7:0]            wr_beat;
  logic                  wr_last, wr_err;

  rd_state_t             rd_state_q, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_start, rd_adv, rd_load, rd_ld_err, rd_ld_bad;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_next_addr, rd_ld_addr;
  logic [7:0]            rd_beat;
  logic                  rd_last, rd_err;

  logic                  unused_ok;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= LIMIT);
  endfunction

  axi_mem_snk_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_SIZE(OFF)) u_wr_addr (
    .clk_i(aclk), .rst_i(areset), .start_i(wr_start),
    .addr_i(awaddr), .len_i(awlen), .size_i(awsize), .burst_i(awburst),
    .advance_i(wr_adv), .addr_o(wr_addr), .next_addr_o(wr_next_addr),
    .beat_o(wr_beat), .last_o(wr_last), .err_o(wr_err)
  );

  axi_mem_snk_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_SIZE(OFF)) u_rd_addr (
    .clk_i(aclk), .rst_i(areset), .start_i(rd_start),
    .addr_i(araddr), .len_i(arlen), .size_i(arsize), .burst_i(arburst),
    .advance_i(rd_adv), .addr_o(rd_addr), .next_addr_o(rd_next_addr),
    .beat_o(rd_beat), .last_o(rd_last), .err_o(rd_err)
  );

  // Write channel: burst length comes from awlen; wlast is only cross-checked.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_acc_d    = wr_acc_q;
    bresp_d     = bresp_q;
    wr_start    = 1'b0;
    wr_adv      = 1'b0;
    wr_we       = 1'b0;
    wr_beat_bad = wr_err || out_of_range(wr_addr);
    wr_acc_now  = wr_acc_q || wr_beat_bad || (wlast != wr_last);
    case (wr_state_q)
      W_IDLE: if (awvalid) begin
        wr_start   = 1'b1;
        wr_acc_d   = 1'b0;
        wr_state_d = W_DATA;
      end
      W_DATA: if (wvalid) begin
        wr_we = !wr_beat_bad;
        if (wr_last) begin
          bresp_d    = wr_acc_now ? RESP_SLVERR : RESP_OKAY;
          wr_state_d = W_RESP;
        end else begin
          wr_adv   = 1'b1;
          wr_acc_d = wr_acc_now;
        end
      end
      W_RESP: if (bready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (wr_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem_q[wr_addr[OFF +: IDX_W]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read channel: each beat's data is fetched one cycle ahead into rdata_q.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_start   = 1'b0;
    rd_adv     = 1'b0;
    rd_load    = 1'b0;
    rd_ld_addr = rd_next_addr;
    rd_ld_err  = rd_err;
    case (rd_state_q)
      R_IDLE: if (arvalid) begin
        rd_start   = 1'b1;
        rd_load    = 1'b1;
        rd_ld_addr = araddr;
        rd_ld_err  = burst_err(arlen, arburst);
        rd_state_d = R_DATA;
      end
      R_DATA: if (rready) begin
        if (rd_last) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_adv  = 1'b1;
          rd_load = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign rd_word   = mem_q[rd_ld_addr[OFF +: IDX_W]];
  assign rd_ld_bad = rd_ld_err || out_of_range(rd_ld_addr);
  assign rdata_d   = rd_load ? (rd_ld_bad ? '0 : rd_word) : rdata_q;
  assign rresp_d   = rd_load ? (rd_ld_bad ? RESP_SLVERR : RESP_OKAY) : rresp_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= W_IDLE;
      wr_acc_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wr_acc_q   <= wr_acc_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign awready = (wr_state_q == W_IDLE);
  assign wready  = (wr_state_q == W_DATA);
  assign bvalid  = (wr_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign arready = (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_DATA);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rvalid && rd_last;

  assign unused_ok = ^{awcache, awlock, awprot, awqos, arcache, arlock, arprot, arqos,
                       wr_next_addr, wr_beat, rd_addr, rd_beat};

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_snk.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_mem_snk
// Desc   : Directed + random bench for axi_mem_snk against a byte-array model.
// Rev    : 1.0
// ============================================================================
module tb_axi_mem_snk;
  localparam int MEM_BYTES = 4096;
  localparam int BYTES     = 4;
  localparam int BOUND     = 400;

  logic        aclk = 1'b0, areset = 1'b1;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0, awprot = '0, arprot = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  awcache = '0, arcache = '0, awqos = '0, arqos = '0, wstrb = '0;
  logic        awlock = 1'b0, arlock = 1'b0;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic        rlast, rvalid, rready = 1'b0;

  int total = 0, bad = 0;
  logic [7:0]  mm [MEM_BYTES];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  always #5 aclk = ~aclk;

  axi_mem_snk dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache), .awlock(awlock), .awprot(awprot), .awqos(awqos),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arlock(arlock), .arprot(arprot), .arqos(arqos),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_size(input int s);
    return (s > 2) ? 2 : s;
  endfunction

  function automatic logic model_err(input int len, input int burst);
    if (burst == 3) return 1'b1;
    if (burst == 2) begin
`ifdef AXI_MEM_SNK_WRAP_EN
      return !(len == 1 || len == 3 || len == 7 || len == 15);
`else
      return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic longint beat_addr(input longint a, input int len, input int size,
                                       input int burst, input int i);
    longint step, al, bnd, base;
    step = longint'(1) << eff_size(size);
    al   = a - (a % step);
    if (i == 0 || burst == 0) return a;
    if (burst == 2) begin
      bnd  = longint'(len + 1) * step;
      base = a - (a % bnd);
      return base + ((al - base + longint'(i) * step) % bnd);
    end
    return al + longint'(i) * step;
  endfunction

  function automatic logic [31:0] model_word(input longint a);
    longint w;
    w = a - (a % BYTES);
    return {mm[w+3], mm[w+2], mm[w+1], mm[w]};
  endfunction

  // ---------------- bus tasks ----------------
  task automatic aw_hs(input logic [31:0] a, input int len, input int size, input int burst);
    int n = 0;
    awaddr = a; awlen = len[7:0]; awsize = size[2:0]; awburst = burst[1:0]; awvalid = 1'b1;
    while (awready !== 1'b1 && n < BOUND) begin @(negedge aclk); n++; end
    check("aw_timeout", 32'(n < BOUND), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (wready !== 1'b1 && n < BOUND) begin @(negedge aclk); n++; end
    check("w_timeout", 32'(n < BOUND), 32'd1);
    @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic write_check(input string tag, input logic [31:0] a, input int len,
                             input int size, input int burst, input int bad_beat);
    int n = 0;
    logic e;
    longint ba;
    e = model_err(len, burst) || (bad_beat >= 0);
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(longint'(a), len, size, burst, i);
      if (model_err(len, burst) || ba >= MEM_BYTES) e = 1'b1;
      else for (int b = 0; b < BYTES; b++)
        if (ws[i][b]) mm[ba - (ba % BYTES) + b] = wd[i][b*8 +: 8];
    end
    aw_hs(a, len, size, burst);
    for (int i = 0; i <= len; i++) w_beat(wd[i], ws[i], (i == len) ^ (i == bad_beat));
    bready = 1'b1;
    while (bvalid !== 1'b1 && n < BOUND) begin @(negedge aclk); n++; end
    check({tag, "_b_timeout"}, 32'(n < BOUND), 32'd1);
    check({tag, "_bresp"}, 32'(bresp), e ? 32'd2 : 32'd0);
    @(negedge aclk);
    bready = 1'b0;
  endtask

  // mode: 0 rready always high, 1 toggling starting low, 2 random
  task automatic read_check(input string tag, input logic [31:0] a, input int len,
                            input int size, input int burst, input int mode);
    logic [31:0] od [256];
    logic [1:0]  orr [256];
    logic        ol [256];
    int          got = 0, cyc = 0, n = 0;
    logic        held_v = 1'b0, held_l = 1'b0, e;
    logic [31:0] held_d = '0;
    longint      ba;
    araddr = a; arlen = len[7:0]; arsize = size[2:0]; arburst = burst[1:0]; arvalid = 1'b1;
    while (arready !== 1'b1 && n < BOUND) begin @(negedge aclk); n++; end
    check({tag, "_ar_timeout"}, 32'(n < BOUND), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    check({tag, "_latency"}, 32'(rvalid), 32'd1);
    while (got <= len && cyc < 4 * BOUND) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      if (held_v) begin
        check($sformatf("%s_stall_d%0d", tag, got), rdata, held_d);
        check($sformatf("%s_stall_l%0d", tag, got), 32'(rlast), 32'(held_l));
      end
      if (rvalid === 1'b1 && rready) begin
        od[got] = rdata; orr[got] = rresp; ol[got] = rlast; got++;
      end
      held_v = (rvalid === 1'b1) && !rready;
      held_d = rdata; held_l = rlast;
      @(negedge aclk);
      cyc++;
    end
    rready = 1'b0;
    check({tag, "_beats"}, 32'(got), 32'(len + 1));
    check({tag, "_done"}, 32'(rvalid), 32'd0);
    for (int i = 0; i < got; i++) begin
      ba = beat_addr(longint'(a), len, size, burst, i);
      e  = model_err(len, burst) || ba >= MEM_BYTES;
      check($sformatf("%s_d%0d", tag, i), od[i], e ? 32'd0 : model_word(ba));
      check($sformatf("%s_r%0d", tag, i), 32'(orr[i]), e ? 32'd2 : 32'd0);
      check($sformatf("%s_l%0d", tag, i), 32'(ol[i]), 32'(i == len));
    end
  endtask

  initial begin
    int len, size, burst, bb;
    logic [31:0] a;
    for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;

    // reset values
    @(negedge aclk);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_rdata",   rdata,        32'd0);
    areset = 1'b0;

    // clear memory so every later read has a known expectation
    for (int i = 0; i < 256; i++) begin wd[i] = '0; ws[i] = 4'hF; end
    for (int k = 0; k < 4; k++) write_check("init", 32'(k * 1024), 255, 2, 1, -1);

    // 1: INCR burst write and read back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    write_check("t1w", 32'h10, 3, 2, 1, -1);
    read_check("t1r", 32'h10, 3, 2, 1, 0);

    // 2: byte strobes
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    write_check("t2w", 32'h20, 0, 2, 1, -1);
    check("t2_model", model_word(32'h20), 32'h00BB00DD);
    read_check("t2r", 32'h20, 0, 2, 1, 0);

    // 3: burst running past end of memory
    wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0; ws[0] = 4'hF; ws[1] = 4'hF;
    write_check("t3w", 32'(MEM_BYTES - 4), 1, 2, 1, -1);
    read_check("t3r", 32'(MEM_BYTES - 4), 1, 2, 1, 0);

    // 4: rready toggling on an 8-beat read
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_check("t4w", 32'h200, 7, 2, 1, -1);
    read_check("t4r", 32'h200, 7, 2, 1, 1);

    // 5: WRAP (expectation depends on build)
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE0000 + 32'(i); ws[i] = 4'hF; end
    write_check("t5w", 32'h38, 3, 2, 2, -1);
    read_check("t5r", 32'h38, 3, 2, 2, 0);
    read_check("t5r30", 32'h30, 3, 2, 1, 0);

    // reserved burst type and wlast mismatch
    write_check("rsvdw", 32'h60, 1, 2, 3, -1);
    read_check("rsvdr", 32'h60, 1, 2, 3, 0);
    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_check("wlastw", 32'h80, 2, 2, 1, 1);
    read_check("wlastr", 32'h80, 2, 2, 1, 0);

    // 6: reset in the middle of a write burst
    wd[0] = 32'h11111111; wd[1] = 32'h22222222;
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < BYTES; b++) mm[32'h100 + 4 * i + b] = wd[i][b*8 +: 8];
    aw_hs(32'h100, 3, 2, 1);
    w_beat(wd[0], 4'hF, 1'b0);
    w_beat(wd[1], 4'hF, 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    check("t6_awready", 32'(awready), 32'd1);
    check("t6_wready",  32'(wready),  32'd0);
    check("t6_bvalid",  32'(bvalid),  32'd0);
    areset = 1'b0;
    read_check("t6r_part", 32'h100, 3, 2, 1, 0);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_check("t6w", 32'h100, 3, 2, 1, -1);
    read_check("t6r", 32'h100, 3, 2, 1, 2);

    // random bursts
    for (int k = 0; k < 24; k++) begin
      a     = 32'($urandom_range(0, MEM_BYTES + 32));
      len   = $urandom_range(0, 15);
      size  = $urandom_range(0, 3);
      burst = $urandom_range(0, 9);
      burst = (burst < 3) ? 0 : (burst < 8) ? 1 : (burst == 8) ? 2 : 3;
      if (burst == 2) begin
        len = (4 << $urandom_range(0, 2)) - 1;
        a   = a & ~((32'd1 << eff_size(size)) - 32'd1);
      end
      bb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      write_check($sformatf("rnd%0dw", k), a, len, size, burst, bb);
      read_check($sformatf("rnd%0dr", k), a, len, size, burst, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
